// File: rtl/chess_pkg.sv
// Shared definitions for the chess keyboard path.
// Holds the game command opcodes, the PS/2 set-2 scan codes used by the
// board controls, and a helper that classifies a scan code into a command.
// No ports; imported with "import chess_pkg::*".

package chess_pkg;

    // Opcodes delivered to the Play engine.
    typedef enum logic [2:0] {
        CMD_UP     = 3'd0,
        CMD_DOWN   = 3'd1,
        CMD_LEFT   = 3'd2,
        CMD_RIGHT  = 3'd3,
        CMD_SELECT = 3'd4,
        CMD_PROMO  = 3'd5
    } cmd_op_t;

    // Set-2 scan codes (make codes, no E0 prefix).
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Which player a key belongs to; Esc belongs to nobody in particular.
    typedef enum logic [1:0] {
        SIDE_ANY   = 2'd0,
        SIDE_WHITE = 2'd1,
        SIDE_BLACK = 2'd2
    } key_side_t;

    typedef struct packed {
        logic      hit;    // code is one of the mapped keys
        logic      flush;  // Esc: internal flush, never queued
        logic      move;   // movement key, eligible for auto-repeat
        key_side_t side;
        cmd_op_t   op;
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m = '0;
        m.hit = 1'b1;
        case (code)
            SC_W:     begin m.op = CMD_UP;     m.move = 1'b1; m.side = SIDE_WHITE; end
            SC_S:     begin m.op = CMD_DOWN;   m.move = 1'b1; m.side = SIDE_WHITE; end
            SC_A:     begin m.op = CMD_LEFT;   m.move = 1'b1; m.side = SIDE_WHITE; end
            SC_D:     begin m.op = CMD_RIGHT;  m.move = 1'b1; m.side = SIDE_WHITE; end
            SC_I:     begin m.op = CMD_UP;     m.move = 1'b1; m.side = SIDE_BLACK; end
            SC_K:     begin m.op = CMD_DOWN;   m.move = 1'b1; m.side = SIDE_BLACK; end
            SC_J:     begin m.op = CMD_LEFT;   m.move = 1'b1; m.side = SIDE_BLACK; end
            SC_L:     begin m.op = CMD_RIGHT;  m.move = 1'b1; m.side = SIDE_BLACK; end
            SC_SPACE: begin m.op = CMD_SELECT; m.side = SIDE_WHITE; end
            SC_G:     begin m.op = CMD_PROMO;  m.side = SIDE_WHITE; end
            SC_ESC:   begin m.flush = 1'b1; end
            default:  begin m.hit = 1'b0; end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with a registered head.
// The head (head_valid/head_data) is a true register loaded from the
// next-state of the queue, so the consumer sees glitch-free outputs.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   enqueue request and payload
//   pop               dequeue request (ignored when empty)
//   flush             discard all entries this cycle (wins over push/pop)
//   full, empty       queue status for the current cycle
//   head_valid        registered "queue not empty"
//   head_data         registered oldest entry
// DEPTH must be a power of two, 2..16.

module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on a full queue frees the slot the push needs, so both proceed.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_next = rd_ptr + {{AW{1'b0}}, do_pop};
        wr_next = wr_ptr + {{AW{1'b0}}, do_push};
        head_next = mem[rd_next[AW-1:0]];
        // The write slot can only equal the new read slot when the queue
        // is (about to be) empty, so the pushed word becomes the head.
        if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
            end
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            head_valid <= (wr_next != rd_next);
            head_data  <= head_next;
        end
    end

endmodule

// File: rtl/key_cmd_sched.sv
// Keyboard-to-game command scheduler.
// Converts level-held make/break events from the Keyboard decoder into
// one-shot game commands, auto-repeats held movement keys, and queues the
// commands for Play behind a valid/ready handshake.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   key_event    [10] valid, [9] E0 extended, [8] break, [7:0] scan code
//   turn         side to move (0 white, 1 black)
//   cmd_ready    Play accepts the presented command
//   cmd_valid    command presented (registered)
//   cmd_op       command opcode (registered, stable until accepted)
//   overflow     sticky: a command was dropped on a full queue
//   repeating    auto-repeat counter armed
// Optional feature macro: KEY_TURN_GATE_EN restricts WASD/Space/G to white
// and IJKL to black, and clears auto-repeat on a turn change.

module key_cmd_sched
    import chess_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] key_event,
    input  logic        turn,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    output logic        overflow,
    output logic        repeating
);

    logic [9:0]  prev_key;
    logic        new_event;
    logic        ev_vld_q;
    logic        ev_ext_q;
    logic        ev_brk_q;
    logic [7:0]  ev_code_q;

    logic [7:0]  held_code;
    cmd_op_t     held_op;
    logic [31:0] rep_cnt;

    key_map_t    km;
    logic        gate_ok;
    logic        key_valid;
    logic        key_push;
    logic        key_release;
    logic        do_flush;
    logic        rep_fire;
    logic        push_req;
    cmd_op_t     push_op;
    logic        pop;
    logic        drop;
    logic        fifo_full;
    logic        unused_fifo_empty;

    // Keyboard holds its last event, so only a change marks a fresh one.
    assign new_event = key_event[10] && (key_event[9:0] != prev_key);

    // Capture stage: the event is decoded one cycle after it is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_key  <= '0;
            ev_vld_q  <= 1'b0;
            ev_ext_q  <= 1'b0;
            ev_brk_q  <= 1'b0;
            ev_code_q <= '0;
        end else begin
            prev_key  <= key_event[9:0];
            ev_vld_q  <= new_event;
            ev_ext_q  <= key_event[9];
            ev_brk_q  <= key_event[8];
            ev_code_q <= key_event[7:0];
        end
    end

`ifdef KEY_TURN_GATE_EN
    logic turn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            turn_q <= 1'b0;
        end else begin
            turn_q <= turn;
        end
    end
`else
    logic [2:0] unused_gate;
    assign unused_gate = {turn, km.side};
`endif

    // Decode: classify the captured event and decide what to push.
    always_comb begin
        km      = map_key(ev_code_q);
        gate_ok = 1'b1;
`ifdef KEY_TURN_GATE_EN
        if ((km.side == SIDE_WHITE) && turn) begin
            gate_ok = 1'b0;
        end
        if ((km.side == SIDE_BLACK) && !turn) begin
            gate_ok = 1'b0;
        end
`endif
        key_valid   = ev_vld_q && !ev_ext_q && km.hit;
        do_flush    = key_valid && !ev_brk_q && km.flush && gate_ok;
        // A make matching the held key is keyboard typematic, not a new press.
        key_push    = key_valid && !ev_brk_q && !km.flush && gate_ok &&
                      (ev_code_q != held_code);
        key_release = key_valid && ev_brk_q && (ev_code_q == held_code);
        rep_fire    = repeating && (rep_cnt == 32'd1);
        // A key push shadows a coincident repeat push; flush drops both.
        push_req    = (key_push || rep_fire) && !do_flush;
        push_op     = key_push ? km.op : held_op;
    end

    assign pop  = cmd_valid && cmd_ready;
    assign drop = push_req && fifo_full && !pop;

    // Held-key, auto-repeat and overflow state. Later assignments take
    // priority, so a key action overrides the free-running repeat reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_code <= '0;
            held_op   <= CMD_UP;
            rep_cnt   <= '0;
            repeating <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (repeating) begin
                if (rep_cnt == 32'd1) begin
                    rep_cnt <= 32'(REPEAT_PERIOD);
                end else begin
                    rep_cnt <= rep_cnt - 32'd1;
                end
            end
`ifdef KEY_TURN_GATE_EN
            if (turn != turn_q) begin
                repeating <= 1'b0;
            end
`endif
            if (key_push) begin
                held_code <= ev_code_q;
                held_op   <= km.op;
                if (km.move) begin
                    rep_cnt   <= 32'(REPEAT_DELAY);
                    repeating <= 1'b1;
                end else begin
                    repeating <= 1'b0;
                end
            end
            if (key_release) begin
                held_code <= '0;
                repeating <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (do_flush) begin
                held_code <= '0;
                repeating <= 1'b0;
                overflow  <= 1'b0;
            end
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_req),
        .push_data  (push_op),
        .pop        (pop),
        .flush      (do_flush),
        .full       (fifo_full),
        .empty      (unused_fifo_empty),
        .head_valid (cmd_valid),
        .head_data  (cmd_op)
    );

endmodule

// File: tb/tb_key_cmd_sched.sv
// Self-checking bench for key_cmd_sched with short repeat timing.
// Expected commands are queued as keys are driven and matched against
// every accepted command by a monitor.

module tb_key_cmd_sched;
    import chess_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] key_event;
    logic        turn;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic        overflow;
    logic        repeating;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [2:0]  exp_q[$];
    int          acc_cyc[$];
    logic [2:0]  exp_head;

    key_cmd_sched #(
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_event (key_event),
        .turn      (turn),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .overflow  (overflow),
        .repeating (repeating)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one key event for a cycle; optionally record the command it should yield.
    task automatic applyStimulus(input logic brk, input logic [7:0] code,
                                 input logic expect_cmd, input logic [2:0] exp_op);
        key_event = {1'b1, 1'b0, brk, code};
        if (expect_cmd) exp_q.push_back(exp_op);
        tick();
    endtask

    // Scoreboard: every accepted command must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_cmd", int'(cmd_op), -1);
            end else begin
                exp_head = exp_q.pop_front();
                checkOutput("cmd_op", int'(cmd_op), int'(exp_head));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        key_event = '0;
        turn      = 1'b0;
        cmd_ready = 1'b0;
        tick(3);
        checkOutput("rst_valid", cmd_valid, 0);
        checkOutput("rst_op", cmd_op, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_rep", repeating, 0);
        rst = 1'b0;
        tick(2);

        $display("[TB] single make");
        cmd_ready = 1'b1;
        applyStimulus(1'b0, SC_W, 1'b1, CMD_UP);
        checkOutput("sm_lat1_valid", cmd_valid, 0);
        tick();
        checkOutput("sm_lat2_valid", cmd_valid, 1);
        checkOutput("sm_lat2_op", cmd_op, CMD_UP);
        tick();
        checkOutput("sm_pulse_end", cmd_valid, 0);
        applyStimulus(1'b1, SC_W, 1'b0, 3'd0);
        tick(6);
        checkOutput("sm_drain", exp_q.size(), 0);

        $display("[TB] hold and repeat");
        acc_cyc.delete();
        applyStimulus(1'b0, SC_D, 1'b1, CMD_RIGHT);
        for (int i = 0; i < 3; i++) exp_q.push_back(CMD_RIGHT);
        tick();
        checkOutput("hold_rep_on", repeating, 1);
        tick(17);
        applyStimulus(1'b1, SC_D, 1'b0, 3'd0);
        tick(10);
        checkOutput("hold_rep_off", repeating, 0);
        checkOutput("hold_count", acc_cyc.size(), 4);
        if (acc_cyc.size() > 1) checkOutput("hold_gap1", acc_cyc[1] - acc_cyc[0], DELAY);
        if (acc_cyc.size() > 2) checkOutput("hold_gap2", acc_cyc[2] - acc_cyc[0], DELAY + PERIOD);
        if (acc_cyc.size() > 3) checkOutput("hold_gap3", acc_cyc[3] - acc_cyc[0], DELAY + 2 * PERIOD);

        $display("[TB] backpressure and overflow");
        cmd_ready = 1'b0;
        applyStimulus(1'b0, SC_W, 1'b1, CMD_UP);
        applyStimulus(1'b0, SC_S, 1'b1, CMD_DOWN);
        applyStimulus(1'b0, SC_A, 1'b1, CMD_LEFT);
        applyStimulus(1'b0, SC_D, 1'b1, CMD_RIGHT);
        applyStimulus(1'b0, SC_SPACE, 1'b0, 3'd0);
        tick(3);
        checkOutput("bp_ovf", overflow, 1);
        checkOutput("bp_valid", cmd_valid, 1);
        checkOutput("bp_head", cmd_op, CMD_UP);
        checkOutput("bp_rep_off", repeating, 0);
        cmd_ready = 1'b1;
        tick(8);
        checkOutput("bp_drain", exp_q.size(), 0);
        checkOutput("bp_empty", cmd_valid, 0);

        $display("[TB] typematic");
        applyStimulus(1'b0, SC_W, 1'b1, CMD_UP);
        key_event = '0;
        tick();
        applyStimulus(1'b0, SC_W, 1'b0, 3'd0);
        applyStimulus(1'b1, SC_W, 1'b0, 3'd0);
        tick(6);
        checkOutput("tm_drain", exp_q.size(), 0);

        $display("[TB] escape flush");
        cmd_ready = 1'b0;
        applyStimulus(1'b0, SC_S, 1'b0, 3'd0);
        applyStimulus(1'b0, SC_A, 1'b0, 3'd0);
        applyStimulus(1'b0, SC_D, 1'b0, 3'd0);
        checkOutput("esc_ovf_before", overflow, 1);
        applyStimulus(1'b0, SC_ESC, 1'b0, 3'd0);
        checkOutput("esc_valid_before", cmd_valid, 1);
        tick();
        checkOutput("esc_valid_after", cmd_valid, 0);
        checkOutput("esc_ovf_after", overflow, 0);
        checkOutput("esc_rep_after", repeating, 0);
        cmd_ready = 1'b1;
        tick(12);

        $display("[TB] turn gate");
        turn = 1'b1;
`ifdef KEY_TURN_GATE_EN
        applyStimulus(1'b0, SC_W, 1'b0, 3'd0);
`else
        applyStimulus(1'b0, SC_W, 1'b1, CMD_UP);
`endif
        applyStimulus(1'b0, SC_I, 1'b1, CMD_UP);
        applyStimulus(1'b1, SC_I, 1'b0, 3'd0);
        tick(6);
        checkOutput("turn_drain", exp_q.size(), 0);
        turn = 1'b0;
        tick(2);

        $display("[TB] reset mid-operation");
        cmd_ready = 1'b0;
        applyStimulus(1'b0, SC_S, 1'b0, 3'd0);
        applyStimulus(1'b0, SC_A, 1'b0, 3'd0);
        tick(3);
        checkOutput("mr_valid_before", cmd_valid, 1);
        checkOutput("mr_rep_before", repeating, 1);
        key_event = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_valid", cmd_valid, 0);
        checkOutput("mr_op", cmd_op, 0);
        checkOutput("mr_ovf", overflow, 0);
        checkOutput("mr_rep", repeating, 0);
        cmd_ready = 1'b1;
        tick(20);
        checkOutput("mr_quiet", cmd_valid, 0);

        checkOutput("sb_final", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
